uart_mmio_bridge: RTL
=====================

// Module: uart_mmio_bridge
// PURPOSE
//  Host-side debug initiator: parses a byte-stream command protocol arriving from the UART receiver
//  and issues single 16-bit MMIO reads/writes on the peripheral bus (0x8000-0x83FF map), then returns
//  a reply through the UART transmitter. It replaces forced-bus testbench pokes with real hardware.
//  Sits between the UART byte interface and a second initiator port of the periph bus arbiter.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  idle cycles allowed between bytes of one command before it is discarded
//  BUS_WAIT_MAX    15      max cycles to wait for bus_ready before aborting the access
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-low
//  rx_valid   in   1   one-cycle pulse: rx_data holds a received byte
//  rx_data    in   8   received byte
//  tx_valid   out  1   reply byte available; held until accepted
//  tx_data    out  8   reply byte; stable while tx_valid=1
//  tx_ready   in   1   transmitter accepts tx_data on the cycle tx_valid&tx_ready
//  bus_sel    out  1   access request; asserted until bus_ready
//  bus_we     out  1   write strobe (qualified by bus_sel)
//  bus_re     out  1   read strobe (qualified by bus_sel)
//  bus_addr   out  16  byte address
//  bus_wdata  out  16  write data
//  bus_rdata  in   16  read data, valid on the cycle bus_ready=1
//  bus_ready  in   1   access complete this cycle
//  busy       out  1   command in progress (state != IDLE)
//  err        out  1   one-cycle pulse: timeout, bus abort, bad opcode or rx overrun
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE; tx_valid, bus_sel/we/re, busy, err = 0; addr/wdata/tx_data = 0.
//  Protocol (big-endian): 'W'(0x57) AH AL DH DL -> write, reply 'K'(0x4B);
//   'R'(0x52) AH AL -> read, reply DH DL; any other opcode -> reply '?'(0x3F), err pulse.
//  States: IDLE -> ARGS (count 4 for W, 2 for R) -> BUS -> RESP -> IDLE.
//  IDLE: rx_valid latches opcode; valid opcode -> ARGS with byte count cleared; else RESP('?').
//  ARGS: each rx_valid shifts byte in (AH first); on last byte -> BUS next cycle.
//   Timeout counter clears on every accepted byte; reaching TIMEOUT_CYCLES -> IDLE, no reply, err.
//  BUS: bus_sel=1 plus we or re, addr/wdata stable from first cycle; hold until bus_ready.
//   bus_ready=1 on same cycle: read captures bus_rdata at that edge; sel deasserts next cycle.
//   Min latency last rx byte -> bus_sel: 1 cycle; zero-wait access occupies exactly 1 cycle.
//   BUS_WAIT_MAX+1 cycles without ready -> drop strobes, reply '!'(0x21), err pulse.
//  RESP: present reply bytes in order; next byte appears the cycle after handshake;
//   tx_valid held with stable data while tx_ready=0; after final handshake -> IDLE.
//  rx_valid in BUS or RESP: byte dropped, err pulse, state unaffected (no queueing).
//  rx_valid and timeout expiry same cycle: byte wins (counter clears).
//  rst mid-access: strobes deassert at that edge; partial command discarded; no reply.
//  Counters saturate; none wrap. bus_we and bus_re never both 1.
// STRUCTURE
//  Shared package (soc_pkg): opcode/reply byte constants (OP_WR, OP_RD, RSP_OK, RSP_BAD, RSP_ABORT),
//   state encoding localparams, MMIO base constants.
//  One sub-module natural: bridge_timeout_ctr (load/clear, saturating count, expiry flag),
//   reused for the inter-byte timeout and the bus-wait limit. FSM, arg shifter, reply mux top-level.
// TESTING
//  1 Bytes 57 83 00 00 5A, bus_ready tied 1 -> one-cycle bus_sel/we, addr 0x8300, wdata 0x005A; tx 0x4B.
//  2 Bytes 52 83 01, bus_rdata=0x0002 on ready -> one-cycle bus_re, addr 0x8301; tx 0x00 then 0x02.
//  3 Byte 41 -> no bus activity; tx 0x3F; err pulses once; busy low after handshake.
//  4 Bytes 57 83 (then silence TIMEOUT_CYCLES) -> err pulse, IDLE, no tx; then full write succeeds.
//  5 Read with bus_ready low 3 cycles -> sel/re held stable 4 cycles; bus_ready never -> tx 0x21.
//  6 tx_ready low 20 cycles during read reply -> tx_data stays 0x00; extra rx byte -> err, reply intact;
//    rst low during BUS -> strobes 0 next edge, busy 0.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared constants and state type for the UART-to-MMIO debug bridge.
package soc_pkg;

    localparam logic [7:0] OP_WR     = 8'h57;
    localparam logic [7:0] OP_RD     = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;
    localparam logic [7:0] RSP_ABORT = 8'h21;

    localparam logic [15:0] MMIO_BASE = 16'h8000;
    localparam logic [15:0] MMIO_LAST = 16'h83FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARGS,
        ST_BUS,
        ST_RESP
    } bridge_state_e;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; expired is high once LIMIT is reached.
module bridge_timeout_ctr #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned WIDTH = $clog2(LIMIT + 1);

    logic [WIDTH-1:0] count;

    assign expired = (count == LIMIT[WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Byte-stream command parser that issues single 16-bit MMIO reads/writes and replies over the UART.
module uart_mmio_bridge
    import soc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned BUS_WAIT_MAX   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_sel,
    output logic        bus_we,
    output logic        bus_re,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ready,
    output logic        busy,
    output logic        err
);

    bridge_state_e state, state_next;

    logic [7:0]  opcode;
    logic [1:0]  arg_idx;
    logic [15:0] rdata_q;
    logic [7:0]  rsp_byte;
    logic        rsp_read;
    logic        resp_idx;
    logic        is_read;
    logic        args_last;
    logic        resp_last;
    logic        tx_fire;
    logic        timeout_hit;
    logic        wait_hit;
    logic        err_next;

    assign is_read   = (opcode == OP_RD);
    assign args_last = is_read ? (arg_idx == 2'd1) : (arg_idx == 2'd3);
    assign resp_last = !rsp_read || resp_idx;
    assign tx_fire   = tx_valid && tx_ready;

    // A byte arriving on the expiry cycle clears the counter, so the byte wins.
    bridge_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_rx_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state != ST_ARGS) || rx_valid),
        .enable  (1'b1),
        .expired (timeout_hit)
    );

    bridge_timeout_ctr #(.LIMIT(BUS_WAIT_MAX)) u_bus_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_BUS),
        .enable  (!bus_ready),
        .expired (wait_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            err   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        state_next = ST_ARGS;
                    end else begin
                        state_next = ST_RESP;
                        err_next   = 1'b1;
                    end
                end
            end
            ST_ARGS: begin
                if (rx_valid) begin
                    if (args_last) state_next = ST_BUS;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end
            end
            ST_BUS: begin
                err_next = rx_valid;
                if (bus_ready) begin
                    state_next = ST_RESP;
                end else if (wait_hit) begin
                    state_next = ST_RESP;
                    err_next   = 1'b1;
                end
            end
            ST_RESP: begin
                err_next = rx_valid;
                if (tx_fire && resp_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            opcode    <= '0;
            arg_idx   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
            rsp_byte  <= '0;
            rsp_read  <= 1'b0;
            resp_idx  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        opcode   <= rx_data;
                        arg_idx  <= '0;
                        rsp_byte <= RSP_BAD;
                        rsp_read <= 1'b0;
                        resp_idx <= 1'b0;
                    end
                end
                ST_ARGS: begin
                    if (rx_valid) begin
                        case (arg_idx)
                            2'd0:    bus_addr[15:8]  <= rx_data;
                            2'd1:    bus_addr[7:0]   <= rx_data;
                            2'd2:    bus_wdata[15:8] <= rx_data;
                            default: bus_wdata[7:0]  <= rx_data;
                        endcase
                        if (!args_last) arg_idx <= arg_idx + 2'd1;
                    end
                end
                ST_BUS: begin
                    resp_idx <= 1'b0;
                    if (bus_ready) begin
                        rsp_byte <= RSP_OK;
                        rsp_read <= is_read;
                        if (is_read) rdata_q <= bus_rdata;
                    end else if (wait_hit) begin
                        rsp_byte <= RSP_ABORT;
                        rsp_read <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (tx_fire && !resp_last) resp_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign tx_valid = (state == ST_RESP);
    assign bus_sel  = (state == ST_BUS);
    assign bus_we   = bus_sel && !is_read;
    assign bus_re   = bus_sel && is_read;

    always_comb begin
        tx_data = '0;
        if (state == ST_RESP) begin
            if (rsp_read) tx_data = resp_idx ? rdata_q[7:0] : rdata_q[15:8];
            else          tx_data = rsp_byte;
        end
    end

endmodule
